// File: rtl/csa_accumulator.sv
// csa_accumulator
// Sequential multi-operand accumulator using carry-save compression.
// Each accepted operand is folded into a redundant (sum, carry) pair in
// one cycle without carry propagation. The final operand of a packet
// starts a chunked carry-propagate resolve, CHUNK bits per cycle. The
// binary result is then presented on a valid/ready output.
//
// Ports:
//   iClk    - clock, all state on rising edge
//   iRstN   - asynchronous active-low reset
//   iValid  - operand valid
//   oReady  - block can accept an operand (registered)
//   iData   - unsigned operand, zero-extended to ACC_WIDTH
//   iLast   - final operand of packet, sampled only on an accepted beat
//   oValid  - oResult valid (registered)
//   iReady  - downstream accepts result
//   oResult - packet sum modulo 2^ACC_WIDTH (registered)
//
// ACC_WIDTH must be >= WIDTH and an integer multiple of CHUNK.
module csa_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CHUNK     = 4
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [WIDTH-1:0]     iData,
  input  logic                 iLast,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [ACC_WIDTH-1:0] oResult
);

  localparam int R    = ACC_WIDTH / CHUNK;
  localparam int IDXW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] sreg;
  logic [ACC_WIDTH-1:0] creg;
  logic [ACC_WIDTH-1:0] dext;
  logic [ACC_WIDTH-1:0] snext;
  logic [ACC_WIDTH-1:0] cnext;
  logic [IDXW-1:0]      idx;
  logic                 carry;
  logic [CHUNK-1:0]     schunk;
  logic [CHUNK-1:0]     cchunk;
  logic [CHUNK:0]       csum;
  logic                 ready_q;
  logic                 valid_q;
  logic [ACC_WIDTH-1:0] result_q;
  logic                 accept;

  // Carry-save step: a 3:2 compression of (S, C, D). The majority term is
  // shifted up one bit and its MSB is dropped, which gives modulo
  // 2^ACC_WIDTH wrap for free.
  always_comb begin
    dext   = ACC_WIDTH'(iData);
    snext  = sreg ^ creg ^ dext;
    cnext  = ((sreg & creg) | (sreg & dext) | (creg & dext)) << 1;
    accept = iValid & ready_q & (state == ACCUM);
  end

  // Select the chunk being resolved this cycle and add it with the carry
  // from the previous chunk. The top bit of csum is the chunk carry-out.
  always_comb begin
    schunk = '0;
    cchunk = '0;
    for (int k = 0; k < R; k++) begin
      if (idx == IDXW'(k)) begin
        schunk = sreg[k*CHUNK +: CHUNK];
        cchunk = creg[k*CHUNK +: CHUNK];
      end
    end
    csum = {1'b0, schunk} + {1'b0, cchunk} + {{CHUNK{1'b0}}, carry};
  end

  // Control FSM with registered handshake outputs. oReady is computed one
  // cycle ahead so it never depends combinationally on iValid/iReady, and
  // it comes up on the first edge after reset is released.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= ACCUM;
      sreg     <= '0;
      creg     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        ACCUM: begin
          ready_q <= 1'b1;
          if (accept) begin
            sreg <= snext;
            creg <= cnext;
            if (iLast) begin
              state   <= RESOLVE;
              idx     <= '0;
              carry   <= 1'b0;
              ready_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          for (int k = 0; k < R; k++) begin
            if (idx == IDXW'(k)) begin
              result_q[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
            end
          end
          carry <= csum[CHUNK];
          // The carry out of the top chunk is discarded by the modulo wrap.
          if (idx == IDXW'(R - 1)) begin
            state   <= OUTPUT;
            valid_q <= 1'b1;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        OUTPUT: begin
          if (iReady) begin
            sreg    <= '0;
            creg    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  assign oReady  = ready_q;
  assign oValid  = valid_q;
  assign oResult = result_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator
// Directed-vector bench for csa_accumulator. Expected packet sums are
// pushed into a queue when a packet's last beat is issued; a monitor pops
// and compares on every result handshake. Handshake timing, backpressure
// and reset behaviour are checked inline by the stimulus process.
module tb_csa_accumulator;

  logic        iClk   = 1'b0;
  logic        iRstN  = 1'b1;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [7:0]  iData  = 8'h00;
  logic        iLast  = 1'b0;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [15:0] oResult;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expq[$];

  csa_accumulator #(
    .WIDTH(8),
    .ACC_WIDTH(16),
    .CHUNK(4)
  ) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .iValid(iValid),
    .oReady(oReady),
    .iData(iData),
    .iLast(iLast),
    .oValid(oValid),
    .iReady(iReady),
    .oResult(oResult)
  );

  // Free-running 10 ns clock
  always #5 iClk = ~iClk;

  // Single comparison point feeding the pass/fail counters
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Monitor: the handshake completes on the next rising edge, so the
  // result is sampled on the falling edge before it.
  always @(negedge iClk) begin
    if (iRstN && oValid && iReady) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got 0x%0h, expected none", oResult);
      end else begin
        checkOutput("result", {16'h0, oResult}, {16'h0, expq.pop_front()});
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!oReady && n < 100) begin
      @(posedge iClk);
      #1;
      n++;
    end
    if (!oReady) reportTimeout("oReady");
  endtask

  // Drive one beat; returns 1 time unit after the accepting edge
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    waitReady();
    iValid = 1'b1;
    iData  = d;
    iLast  = last;
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iValid = 1'b0;
    iLast  = 1'b0;
    iData  = 8'h00;
  endtask

  // Count edges from the last-beat accept until oValid rises, optionally
  // confirming oReady stays low throughout the resolve phase.
  task automatic waitValid(output int cyc, input bit checkBusy);
    cyc = 0;
    while (!oValid && cyc < 50) begin
      if (checkBusy) checkOutput("oReady low in resolve", {31'h0, oReady}, 32'h0);
      @(posedge iClk);
      #1;
      cyc++;
    end
    if (!oValid) reportTimeout("oValid");
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;

    // Reset state
    #2 iRstN = 1'b0;
    #1;
    checkOutput("reset oReady", {31'h0, oReady}, 32'h0);
    checkOutput("reset oValid", {31'h0, oValid}, 32'h0);
    checkOutput("reset oResult", {16'h0, oResult}, 32'h0);
    repeat (3) @(posedge iClk);
    @(negedge iClk) iRstN = 1'b1;
    @(posedge iClk);
    #1;
    checkOutput("oReady after reset", {31'h0, oReady}, 32'h1);

    // Test 1: single-operand packet, latency and one-cycle oValid
    $display("[TB] test 1: single beat 0xFF");
    iReady = 1'b1;
    expq.push_back(16'h00FF);
    applyStimulus(8'hFF, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    checkOutput("t1 latency", cyc, 32'd4);
    checkOutput("t1 oReady in output", {31'h0, oReady}, 32'h0);
    @(posedge iClk);
    #1;
    checkOutput("t1 oValid one cycle", {31'h0, oValid}, 32'h0);

    // Test 2: three back-to-back beats
    $display("[TB] test 2: 3 x 0xFF");
    expq.push_back(16'h02FD);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'hFF, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    checkOutput("t2 latency", cyc, 32'd4);
    checkOutput("t2 oReady in output", {31'h0, oReady}, 32'h0);
    @(posedge iClk);
    #1;

    // Test 3: 300 beats of 0xFF, wraps modulo 2^16
    $display("[TB] test 3: 300 x 0xFF");
    expq.push_back(16'h2AD4);
    for (int i = 0; i < 300; i++) applyStimulus(8'hFF, (i == 299));
    idle();
    waitValid(cyc, 1'b0);
    checkOutput("t3 latency", cyc, 32'd4);
    @(posedge iClk);
    #1;

    // Test 4: backpressure with junk operands presented during OUTPUT
    $display("[TB] test 4: backpressure");
    iReady = 1'b0;
    expq.push_back(16'h0030);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1;
      iData  = 8'hAA;
      iLast  = 1'b0;
      @(posedge iClk);
      #1;
      checkOutput("t4 oValid held", {31'h0, oValid}, 32'h1);
      checkOutput("t4 oReady held low", {31'h0, oReady}, 32'h0);
      checkOutput("t4 oResult stable", {16'h0, oResult}, 32'h0030);
    end
    idle();
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    expq.push_back(16'h0001);
    applyStimulus(8'h01, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    @(posedge iClk);
    #1;

    // Test 5: reset asserted mid-resolve discards the packet
    $display("[TB] test 5: reset during resolve");
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'h7F, 1'b1);
    idle();
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRstN = 1'b0;
    #1;
    checkOutput("t5 oValid in reset", {31'h0, oValid}, 32'h0);
    checkOutput("t5 oResult in reset", {16'h0, oResult}, 32'h0);
    checkOutput("t5 oReady in reset", {31'h0, oReady}, 32'h0);
    repeat (2) @(posedge iClk);
    @(negedge iClk) iRstN = 1'b1;
    @(posedge iClk);
    #1;
    checkOutput("t5 oReady after reset", {31'h0, oReady}, 32'h1);
    checkOutput("t5 no stale oValid", {31'h0, oValid}, 32'h0);
    expq.push_back(16'h0003);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    checkOutput("t5 latency", cyc, 32'd4);
    @(posedge iClk);
    #1;

    // Test 6: iLast without iValid is ignored, then back-to-back packets
    $display("[TB] test 6: back-to-back packets");
    iLast = 1'b1;
    @(posedge iClk);
    #1;
    iLast = 1'b0;
    checkOutput("t6 stray iLast ignored", {31'h0, oReady}, 32'h1);
    expq.push_back(16'h0005);
    expq.push_back(16'h0006);
    applyStimulus(8'h05, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    @(posedge iClk);
    #1;
    checkOutput("t6 oValid dropped", {31'h0, oValid}, 32'h0);
    checkOutput("t6 oReady one cycle after handshake", {31'h0, oReady}, 32'h1);
    applyStimulus(8'h06, 1'b1);
    idle();
    waitValid(cyc, 1'b1);
    checkOutput("t6 latency", cyc, 32'd4);
    @(posedge iClk);
    #1;

    repeat (2) @(posedge iClk);
    #1;
    checkOutput("scoreboard drained", expq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
